alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//   Control stage directly upstream of the RegA/RegB/ALU datapath.
//   - Accepts an operation request: two 4-bit operands plus add/sub, with a start/done handshake.
//   - Drives the datapath operand inputs and its LatchA/LatchB/AddSub/EnableAlu/EnableA controls.
//   - Waits for the ripple ALU to settle, then registers the sum/difference, carry and signed overflow.
// PARAMETERS
//   WIDTH          4  operand/result width; the datapath is 4 bits, so only 4 is supported
//   SETTLE_CYCLES  1  full MainClock cycles in SETTLE before capture (legal range 1..7)
// PORTS
//   MainClock   in   1      single clock
//   MainReset   in   1      asynchronous, active-high reset
//   start       in   1      request pulse; sampled only in IDLE
//   op_sub      in   1      0: result=B+A, 1: result=B-A
//   operand_a   in   WIDTH  A operand, sampled with start
//   operand_b   in   WIDTH  B operand, sampled with start
//   peek_a      in   1      in IDLE, drive EnableA to put stored A on the A bus
//   alu_result  in   WIDTH  datapath ALU output (digit3)
//   alu_carry   in   1      datapath carry out (out1)
//   a_data      out  WIDTH  to datapath A inputs
//   b_data      out  WIDTH  to datapath B inputs
//   LatchA      out  1      A register load strobe; datapath gates it with MainClock
//   LatchB      out  1      B register load strobe; datapath gates it with MainClock
//   AddSub      out  1      datapath add/sub select
//   EnableAlu   out  1      ALU tristate enable
//   EnableA     out  1      A tristate enable
//   busy        out  1      high from the cycle after start is accepted until done
//   done        out  1      one-cycle pulse; result, carry and ovf are valid from then on
//   result      out  WIDTH  registered ALU result
//   carry       out  1      registered carry (sub: 1 = no borrow)
//   ovf         out  1      registered two's-complement overflow
// BEHAVIOUR
//   Reset (async, immediate)
//   - State goes to IDLE. Every output is 0, including the strobes, which drop asynchronously.
//   - The hold registers and the settle counter clear.
//   - A reset mid-operation aborts the operation. done never fires for it, and the previous result is lost (cleared to 0).
//   Clocking
//   - The FSM, hold registers and result registers update on posedge MainClock.
//   - LatchA, LatchB, AddSub, EnableAlu and EnableA are retimed through negedge flops from the FSM decode.
//   - Each strobe is therefore stable across the whole high phase of MainClock, so the datapath's clock AND gate is glitch-free.
//   - The datapath captures at the posedge that ends the state that requested the strobe.
//   FSM: IDLE -> LOAD_A -> LOAD_B -> SETTLE -> CAPTURE -> DONE -> IDLE
//   - IDLE: if start=1, load hold_a, hold_b and hold_sub and go to LOAD_A. Otherwise stay.
//     EnableA = peek_a in IDLE only.
//   - LOAD_A: a_data = hold_a; LatchA requested. Lasts 1 cycle.
//   - LOAD_B: b_data = hold_b; LatchB requested. Lasts 1 cycle.
//   - SETTLE: AddSub = hold_sub; EnableAlu requested. Lasts SETTLE_CYCLES cycles (counter).
//   - CAPTURE: AddSub and EnableAlu held. At the exit posedge, result <= alu_result and carry <= alu_carry.
//     ovf is computed from hold_a, hold_b, hold_sub and alu_result:
//     - add: ovf = (b[3]==a[3]) && (r[3]!=b[3])
//     - sub: ovf = (b[3]!=a[3]) && (r[3]!=b[3])
//   - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//   Output rules
//   - a_data and b_data hold their last values outside the load states; they are only sampled under a strobe.
//   - AddSub is 0 outside SETTLE/CAPTURE.
//   - result, carry and ovf hold until the next CAPTURE or a reset.
//   Latency
//   - start sampled at edge 0 -> done high during the cycle after edge SETTLE_CYCLES+3 (edge 4 with the default).
//   - Back-to-back: start may be asserted during the DONE cycle, but it is ignored; it is sampled in IDLE at the next edge.
//   Boundaries
//   - start while busy: ignored, with no queueing.
//   - start held high: one operation per IDLE visit.
//   - peek_a while busy: ignored.
//   - Operands changing after acceptance: no effect (hold registers).
// TESTING (bench pairs this block with a behavioural model of the RegA/RegB/ALU datapath)
//   1. a=3, b=5, add -> result=8, carry=0, ovf=1; done at edge 4; busy high for edges 1..3.
//   2. a=2, b=7, sub -> result=5, carry=1, ovf=0; AddSub high only in SETTLE/CAPTURE.
//   3. a=7, b=2, sub -> result=0xB, carry=0, ovf=0.
//   4. a=0xF, b=1, add -> result=0, carry=1, ovf=0; then start with a=1,b=1 during DONE -> ignored; re-assert in IDLE -> result=2.
//   5. MainReset pulsed in SETTLE -> strobes/busy drop at once, result=0, no done; next op a=4, b=4, add -> result=8, ovf=1.
//   6. SETTLE_CYCLES=3 -> done at edge 6. Check that LatchA/LatchB change only on negedges, each high for one cycle.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: control stage in front of the RegA/RegB/ALU datapath.
// Takes one add/sub request at a time, loads the two datapath registers,
// lets the ripple ALU settle, then registers result, carry and overflow.
// Datapath strobes come from negedge flops so they are stable for the
// whole high phase of MainClock (the datapath ANDs them with the clock).
module alu_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             MainClock,
    input  logic             MainReset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             peek_a,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic [WIDTH-1:0] a_data,
    output logic [WIDTH-1:0] b_data,
    output logic             LatchA,
    output logic             LatchB,
    output logic             AddSub,
    output logic             EnableAlu,
    output logic             EnableA,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Last value of the settle counter before moving on to CAPTURE.
    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

    state_t            state_reg;
    logic [WIDTH-1:0]  hold_a_reg;
    logic [WIDTH-1:0]  hold_b_reg;
    logic              hold_sub_reg;
    logic [2:0]        settle_cnt_reg;
    logic [WIDTH-1:0]  a_data_reg;
    logic [WIDTH-1:0]  b_data_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              carry_reg;
    logic              ovf_reg;

    // Strobe requests decoded from the current state, retimed on negedge.
    logic              latch_a_next;
    logic              latch_b_next;
    logic              add_sub_next;
    logic              enable_alu_next;
    logic              enable_a_next;
    logic              latch_a_reg;
    logic              latch_b_reg;
    logic              add_sub_reg;
    logic              enable_alu_reg;
    logic              enable_a_reg;

    logic              ovf_next;

    // Signed overflow judged from the held operands and the settled ALU sum.
    // A subtract overflows when the operand signs differ; an add when they match.
    always_comb begin
        ovf_next = 1'b0;
        if (hold_sub_reg) begin
            ovf_next = (hold_b_reg[WIDTH-1] != hold_a_reg[WIDTH-1]) &&
                       (alu_result[WIDTH-1] != hold_b_reg[WIDTH-1]);
        end else begin
            ovf_next = (hold_b_reg[WIDTH-1] == hold_a_reg[WIDTH-1]) &&
                       (alu_result[WIDTH-1] != hold_b_reg[WIDTH-1]);
        end
    end

    // Main sequencer: state, hold registers, operand buses and result registers.
    always_ff @(posedge MainClock or posedge MainReset) begin
        if (MainReset) begin
            state_reg      <= IDLE;
            hold_a_reg     <= '0;
            hold_b_reg     <= '0;
            hold_sub_reg   <= 1'b0;
            settle_cnt_reg <= '0;
            a_data_reg     <= '0;
            b_data_reg     <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            result_reg     <= '0;
            carry_reg      <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        hold_a_reg   <= operand_a;
                        hold_b_reg   <= operand_b;
                        hold_sub_reg <= op_sub;
                        // A bus must already carry the operand during LOAD_A.
                        a_data_reg   <= operand_a;
                        busy_reg     <= 1'b1;
                        state_reg    <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    b_data_reg <= hold_b_reg;
                    state_reg  <= LOAD_B;
                end
                LOAD_B: begin
                    settle_cnt_reg <= '0;
                    state_reg      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        state_reg <= CAPTURE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 3'd1;
                    end
                end
                CAPTURE: begin
                    result_reg <= alu_result;
                    carry_reg  <= alu_carry;
                    ovf_reg    <= ovf_next;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: begin
                    // start is deliberately not looked at here.
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Decode which datapath strobes the current state is asking for.
    always_comb begin
        latch_a_next    = 1'b0;
        latch_b_next    = 1'b0;
        add_sub_next    = 1'b0;
        enable_alu_next = 1'b0;
        enable_a_next   = 1'b0;
        case (state_reg)
            IDLE:    enable_a_next = peek_a;
            LOAD_A:  latch_a_next  = 1'b1;
            LOAD_B:  latch_b_next  = 1'b1;
            SETTLE, CAPTURE: begin
                add_sub_next    = hold_sub_reg;
                enable_alu_next = 1'b1;
            end
            default: begin
                latch_a_next = 1'b0;
            end
        endcase
    end

    // Retime strobes on the falling edge so they never change while MainClock is high.
    always_ff @(negedge MainClock or posedge MainReset) begin
        if (MainReset) begin
            latch_a_reg    <= 1'b0;
            latch_b_reg    <= 1'b0;
            add_sub_reg    <= 1'b0;
            enable_alu_reg <= 1'b0;
            enable_a_reg   <= 1'b0;
        end else begin
            latch_a_reg    <= latch_a_next;
            latch_b_reg    <= latch_b_next;
            add_sub_reg    <= add_sub_next;
            enable_alu_reg <= enable_alu_next;
            enable_a_reg   <= enable_a_next;
        end
    end

    assign a_data    = a_data_reg;
    assign b_data    = b_data_reg;
    assign LatchA    = latch_a_reg;
    assign LatchB    = latch_b_reg;
    assign AddSub    = add_sub_reg;
    assign EnableAlu = enable_alu_reg;
    assign EnableA   = enable_a_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign result    = result_reg;
    assign carry     = carry_reg;
    assign ovf       = ovf_reg;

endmodule
